// File: rtl/sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sample_sequencer
//  Brief    : Per-sample ADC -> processor -> DAC/PWM controller with channel
//             selection, ADC timeout and dropped-tick accounting.
//  Revision : 1.0 - initial release
// ============================================================================
module sample_sequencer #(
    parameter int DW       = 10,
    parameter int PROC_LAT = 2,
    parameter int TIMEOUT  = 2047
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          tick,
    input  logic [1:0]    chan_mode,
    output logic          adc_start,
    output logic          adc_channel,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_data_valid,
    output logic [DW-1:0] proc_in,
    input  logic [DW-1:0] proc_out,
    output logic [DW-1:0] dac_data,
    output logic          dac_load,
    output logic          busy,
    output logic          timeout_err,
    output logic [7:0]    overrun_cnt,
    input  logic          err_clr
);

    localparam int                 c_TO_W     = 12;
    localparam int                 c_LAT_W    = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(PROC_LAT - 1);
    localparam logic [7:0]         c_OVR_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_ADC_WAIT  = 3'd2,
        S_PROC_WAIT = 3'd3,
        S_LOAD      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [c_TO_W-1:0]    r_to_cnt;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic                 r_alt;
    logic                 r_adc_start;
    logic                 r_adc_channel;
    logic [DW-1:0]        r_proc_in;
    logic [DW-1:0]        r_dac_data;
    logic                 r_dac_load;
    logic                 r_timeout_err;
    logic [7:0]           r_overrun_cnt;

    logic                 w_accept;
    logic                 w_drop;
    logic                 w_capture;
    logic                 w_to_hit;
    logic                 w_lat_done;

    // Ticks only count as drops while enabled; with enable low they are simply ignored.
    assign w_accept   = (r_state == S_IDLE) && tick && enable;
    assign w_drop     = (r_state != S_IDLE) && tick && enable;
    assign w_capture  = (r_state == S_ADC_WAIT) && adc_data_valid;
    assign w_to_hit   = (r_state == S_ADC_WAIT) && !adc_data_valid && (r_to_cnt == c_TO_LAST);
    assign w_lat_done = (r_state == S_PROC_WAIT) && (r_lat_cnt == '0);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_ADC_WAIT;
            end
            S_ADC_WAIT: begin
                if (w_capture) begin
                    w_next = S_PROC_WAIT;
                end else if (w_to_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_PROC_WAIT: begin
                if (w_lat_done) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Start pulse and DAC strobe are registered so they come out of reset at 0.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_start <= 1'b0;
            r_dac_load  <= 1'b0;
            r_dac_data  <= '0;
            r_proc_in   <= '0;
            r_to_cnt    <= '0;
            r_lat_cnt   <= '0;
        end else begin
            r_adc_start <= (r_state == S_START);
            r_dac_load  <= w_lat_done;

            if (w_lat_done) begin
                r_dac_data <= proc_out;
            end

            if (r_state == S_START) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_ADC_WAIT) && !w_capture && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_capture) begin
                r_proc_in <= adc_data;
                r_lat_cnt <= c_LAT_LOAD;
            end else if ((r_state == S_PROC_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_channel <= 1'b0;
            r_alt         <= 1'b0;
        end else if (w_accept) begin
            case (chan_mode)
                2'b00: r_adc_channel <= 1'b0;
                2'b01: r_adc_channel <= 1'b1;
                2'b10: begin
                    r_adc_channel <= r_alt;
                    r_alt         <= ~r_alt;
                end
                default: r_adc_channel <= 1'b1;
            endcase
        end
    end

    // A clear request overrides a same-cycle timeout or drop.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
            r_overrun_cnt <= '0;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end
            if (w_drop && (r_overrun_cnt != c_OVR_MAX)) begin
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
            end
        end
    end

    assign adc_start   = r_adc_start;
    assign adc_channel = r_adc_channel;
    assign proc_in     = r_proc_in;
    assign dac_data    = r_dac_data;
    assign dac_load    = r_dac_load;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;
    assign overrun_cnt = r_overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sample_sequencer
//  Brief    : Scoreboard bench for sample_sequencer (passthrough processor).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_sequencer;

    localparam int DW       = 10;
    localparam int PROC_LAT = 2;
    localparam int TIMEOUT  = 2047;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          tick;
    logic [1:0]    chan_mode;
    logic          adc_start;
    logic          adc_channel;
    logic [DW-1:0] adc_data;
    logic          adc_data_valid;
    logic [DW-1:0] proc_in;
    logic [DW-1:0] proc_out;
    logic [DW-1:0] dac_data;
    logic          dac_load;
    logic          busy;
    logic          timeout_err;
    logic [7:0]    overrun_cnt;
    logic          err_clr;

    int            n_checks = 0;
    int            n_errors = 0;
    int            ncyc = 0;
    int            last_tick_cyc = 0;
    int            last_valid_cyc = 0;
    logic          busy_chk_pending = 1'b0;
    logic          alt_model;
    logic [DW-1:0] last_dac;
    logic [DW-1:0] last_proc;
    logic          exp_chan[$];
    logic [DW-1:0] exp_dac[$];

    always #5 sysclk = ~sysclk;

    assign proc_out = proc_in;

    sample_sequencer #(
        .DW       (DW),
        .PROC_LAT (PROC_LAT),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .sysclk         (sysclk),
        .rst_n          (rst_n),
        .enable         (enable),
        .tick           (tick),
        .chan_mode      (chan_mode),
        .adc_start      (adc_start),
        .adc_channel    (adc_channel),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .proc_in        (proc_in),
        .proc_out       (proc_out),
        .dac_data       (dac_data),
        .dac_load       (dac_load),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .overrun_cnt    (overrun_cnt),
        .err_clr        (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_tick(input logic expect_accept);
        if (expect_accept) begin
            if (chan_mode == 2'b10) begin
                exp_chan.push_back(alt_model);
                alt_model = ~alt_model;
            end else begin
                exp_chan.push_back(chan_mode != 2'b00);
            end
        end
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            if (adc_start) break;
        end
        check("start_seen", adc_start, 1);
    endtask

    task automatic send_valid(input int delay, input logic [DW-1:0] d, input logic expect_load);
        step(delay);
        adc_data       = d;
        adc_data_valid = 1'b1;
        if (expect_load) begin
            exp_dac.push_back(d);
            last_dac = d;
        end
        last_proc = d;
        step(1);
        adc_data_valid = 1'b0;
        adc_data       = '0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) @(negedge sysclk);
        check("idle_reached", busy, 0);
        step(1);
    endtask

    task automatic run_sample(input logic [DW-1:0] d);
        pulse_tick(1'b1);
        wait_start();
        send_valid(10, d, 1'b1);
        wait_idle(20);
    endtask

    // Scoreboard side: channel checked at every start, result at every load.
    initial begin
        forever begin
            @(negedge sysclk);
            ncyc++;
            if (rst_n) begin
                if (busy_chk_pending) begin
                    check("busy_after_load", busy, 0);
                    busy_chk_pending = 1'b0;
                end
                if (tick && enable && !busy) last_tick_cyc = ncyc;
                if (adc_data_valid) last_valid_cyc = ncyc;
                if (adc_start) begin
                    check("start_latency", ncyc - last_tick_cyc, 2);
                    if (exp_chan.size() == 0) check("unexpected_start", adc_start, 0);
                    else check("adc_channel", adc_channel, exp_chan.pop_front());
                end
                if (dac_load) begin
                    check("load_latency", ncyc - last_valid_cyc, PROC_LAT + 1);
                    if (exp_dac.size() == 0) check("unexpected_load", dac_load, 0);
                    else check("dac_data", dac_data, exp_dac.pop_front());
                    busy_chk_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; chan_mode = 2'b00;
        adc_data = '0; adc_data_valid = 1'b0; err_clr = 1'b0;
        alt_model = 1'b0; last_dac = '0; last_proc = '0;
        step(3);
        check("rst_ctrl_outs", {adc_start, adc_channel, dac_load, busy, timeout_err}, 0);
        check("rst_proc_in", proc_in, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_overrun", overrun_cnt, 0);
        rst_n = 1'b1; enable = 1'b1;
        step(2);

        // Basic sample on fixed channel 1
        chan_mode = 2'b01;
        run_sample(10'h2A5);
        check("proc_in_held", proc_in, 10'h2A5);

        // Alternating channel, then fixed modes
        chan_mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            d = DW'(10'h101 + i * 83);
            run_sample(d);
        end
        chan_mode = 2'b00;
        pulse_tick(1'b1);
        wait_start();
        chan_mode = 2'b01;
        step(3);
        check("chan_stable", adc_channel, 0);
        send_valid(4, 10'h0AA, 1'b1);
        wait_idle(20);
        chan_mode = 2'b11;
        run_sample(10'h3E1);
        chan_mode = 2'b10;
        run_sample(10'h1F0);

        // Valid pulse while idle is ignored
        adc_data = 10'h3FF; adc_data_valid = 1'b1;
        step(1);
        adc_data_valid = 1'b0; adc_data = '0;
        step(1);
        check("valid_idle_ignored", proc_in, last_proc);
        check("valid_idle_busy", busy, 0);

        // Overrun counting, clear, saturation, clear priority
        chan_mode = 2'b01;
        pulse_tick(1'b1);
        wait_start();
        step(2);
        repeat (3) begin
            pulse_tick(1'b0);
            step(1);
        end
        check("overrun_3", overrun_cnt, 3);
        send_valid(4, 10'h155, 1'b1);
        wait_idle(20);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("overrun_clr", overrun_cnt, 0);

        pulse_tick(1'b1);
        wait_start();
        step(1);
        tick = 1'b1;
        step(300);
        tick = 1'b0;
        check("overrun_sat", overrun_cnt, 255);
        tick = 1'b1; err_clr = 1'b1;
        step(1);
        tick = 1'b0; err_clr = 1'b0;
        check("clr_wins", overrun_cnt, 0);
        pulse_tick(1'b0);
        check("overrun_after_clr", overrun_cnt, 1);
        send_valid(3, 10'h2C7, 1'b1);
        wait_idle(20);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;

        // ADC timeout boundary
        pulse_tick(1'b1);
        wait_start();
        repeat (TIMEOUT - 1) @(negedge sysclk);
        check("to_err_early", timeout_err, 0);
        check("busy_before_to", busy, 1);
        @(negedge sysclk);
        check("to_err_set", timeout_err, 1);
        check("busy_after_to", busy, 0);
        check("dac_kept", dac_data, last_dac);
        step(1);
        run_sample(10'h0F0);
        check("to_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("to_err_clr", timeout_err, 0);

        // Asynchronous reset during PROC_WAIT
        chan_mode = 2'b10;
        pulse_tick(1'b1);
        wait_start();
        send_valid(3, 10'h1C3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_proc_in", proc_in, 0);
        check("async_rst_dac", dac_data, 0);
        check("async_rst_ctrl", {adc_start, adc_channel, dac_load}, 0);
        alt_model = 1'b0; last_dac = '0; last_proc = '0;
        step(2);
        rst_n = 1'b1;
        step(10);
        check("no_load_after_rst", dac_data, 0);
        run_sample(10'h3C3);

        // Disable after start: sample completes, later ticks ignored
        chan_mode = 2'b01;
        pulse_tick(1'b1);
        wait_start();
        enable = 1'b0;
        send_valid(5, 10'h2D2, 1'b1);
        wait_idle(20);
        repeat (3) begin
            pulse_tick(1'b0);
            step(2);
        end
        step(5);
        check("disabled_busy", busy, 0);
        check("disabled_overrun", overrun_cnt, 0);
        enable = 1'b1;

        check("pending_loads", exp_dac.size(), 0);
        check("pending_starts", exp_chan.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
